// File: rtl/tfhe_axil_cmd_master_pkg.sv
// Shared definitions for the TFHE accelerator AXI4-Lite command master:
// FSM encoding, AXI response codes and the accelerator register map.
package tfhe_axil_cmd_master_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5,
        ERR          = 3'd6
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    // Accelerator control register byte offsets.
    localparam logic [7:0] REG_CTRL        = 8'h00;
    localparam logic [7:0] REG_STATUS      = 8'h04;
    localparam logic [7:0] REG_KEY_BASE    = 8'h08;
    localparam logic [7:0] REG_CT_IN_BASE  = 8'h0C;
    localparam logic [7:0] REG_CT_OUT_BASE = 8'h10;
    localparam logic [7:0] REG_IRQ         = 8'h14;

    // States in which a bus transaction is waiting on the slave.
    function automatic logic in_flight(input state_e s);
        return (s == WR_ADDR_DATA) || (s == WR_RESP) ||
               (s == RD_ADDR)      || (s == RD_DATA);
    endfunction

endpackage

// File: rtl/tfhe_axil_watchdog.sv
// Per-transaction cycle counter; flags expiry after C_TIMEOUT_CYCLES cycles,
// counting the cycle in which the transaction was accepted.
module tfhe_axil_watchdog #(
    parameter int C_TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(C_TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(C_TIMEOUT_CYCLES);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = enable ? CW'(1) : '0;
        end else if (enable && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Expiry fires on the cycle whose increment would make the count reach the limit.
    assign expired = enable && !clear && (count_q >= (LIMIT - 1'b1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tfhe_axil_cmd_master.sv
// Single-outstanding AXI4-Lite master turning simple commands into bus
// reads/writes, with a per-transaction watchdog that parks the FSM in ERR.
module tfhe_axil_cmd_master
    import tfhe_axil_cmd_master_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int C_TIMEOUT_CYCLES   = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a raised valid keeps itself and its payload until that edge.

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;

    logic            cmd_fire;
    logic            aw_fire;
    logic            w_fire;
    logic            ar_fire;
    logic            wdog_clear;
    logic            wdog_enable;
    logic            wdog_expired;

    assign cmd_ready = (state_q == IDLE) && !M_AXI_ARESET;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign aw_fire   = awvalid_q && M_AXI_AWREADY;
    assign w_fire    = wvalid_q && M_AXI_WREADY;
    assign ar_fire   = arvalid_q && M_AXI_ARREADY;

    assign wdog_clear  = cmd_fire;
    assign wdog_enable = cmd_fire || in_flight(state_q);

    tfhe_axil_watchdog #(
        .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (M_AXI_ACLK),
        .rst     (M_AXI_ARESET),
        .clear   (wdog_clear),
        .enable  (wdog_enable),
        .expired (wdog_expired)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        // Each channel valid drops only on its own handshake, in every state.
        awvalid_d   = awvalid_q && !M_AXI_AWREADY;
        wvalid_d    = wvalid_q && !M_AXI_WREADY;
        arvalid_d   = arvalid_q && !M_AXI_ARREADY;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if ((!awvalid_q || aw_fire) && (!wvalid_q || w_fire)) begin
                    state_d = WR_RESP;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            RD_ADDR: begin
                if (ar_fire) begin
                    state_d = RD_DATA;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    state_d     = RESP;
                end else if (wdog_expired) begin
                    state_d = ERR;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign error     = (state_q == ERR);

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = AXI_PROT_DEFAULT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule
